// File: rtl/key_click_classifier_pkg.sv
// Shared definitions for the key click classifier: FSM state codes, default
// timing constants and the saturating click-count helper.
package key_click_classifier_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_EMIT = 2'd2
  } state_e;

  // 250 ms window at a 50 MHz system clock
  localparam int DEFAULT_WINDOW_CYC = 12_500_000;
  localparam int DEFAULT_MAX_CLICKS = 3;

  function automatic int sat_inc(input int cnt, input int max_val);
    int res;
    if (cnt >= max_val) begin
      res = max_val;
    end else begin
      res = cnt + 1;
    end
    return res;
  endfunction

endpackage

// File: rtl/key_click_classifier_click_window_timer.sv
// Inter-press window timer: counts idle cycles of an open click sequence and
// raises a registered expire strobe once the count reaches WINDOW_CYC-1.
module click_window_timer #(
  parameter int WINDOW_CYC = 12_500_000,
  localparam int TMR_W = $clog2(WINDOW_CYC)
) (
  input  logic CLK,
  input  logic RSTn,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  logic [TMR_W-1:0] timer_r;
  logic [TMR_W-1:0] timer_nxt_s;

  // Next timer value: clear has priority over counting
  always_comb begin
    timer_nxt_s = timer_r;
    if (clear) begin
      timer_nxt_s = {TMR_W{1'b0}};
    end else if (enable) begin
      timer_nxt_s = timer_r + TMR_W'(1);
    end else begin
      timer_nxt_s = timer_r;
    end
  end

  // Timer register; expire is precomputed so it tracks the registered count
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      timer_r <= {TMR_W{1'b0}};
      expire  <= 1'b0;
    end else begin
      timer_r <= timer_nxt_s;
      expire  <= (timer_nxt_s == TMR_W'(WINDOW_CYC - 1));
    end
  end

endmodule

// File: rtl/key_click_classifier.sv
// Groups debounced press pulses into single/double/multi click events.
// Optional Click_Cnt output is enabled by defining CLICK_CNT_OUT_EN.
module key_click_classifier
  import key_click_classifier_pkg::*;
#(
  parameter int WINDOW_CYC = DEFAULT_WINDOW_CYC,
  parameter int MAX_CLICKS = DEFAULT_MAX_CLICKS,
  localparam int CNT_W = $clog2(MAX_CLICKS + 1)
) (
  input  logic             CLK,
  input  logic             RSTn,
  input  logic             Press_Pulse,
  output logic             Single_Sig,
  output logic             Double_Sig,
  output logic             Multi_Sig,
  output logic             Busy
`ifdef CLICK_CNT_OUT_EN
  ,
  output logic [CNT_W-1:0] Click_Cnt
`endif
);

  state_e           state_r;
  logic [CNT_W-1:0] count_r;
  logic [CNT_W-1:0] count_inc_s;
  logic             timer_clear_s;
  logic             timer_en_s;
  logic             timer_expire_s;

  // Timer only runs in WAIT with no press; any press or other state restarts it
  always_comb begin
    count_inc_s   = CNT_W'(sat_inc(int'(count_r), MAX_CLICKS));
    timer_clear_s = Press_Pulse || (state_r != ST_WAIT);
    timer_en_s    = (state_r == ST_WAIT) && !Press_Pulse && !timer_expire_s;
  end

  click_window_timer #(
    .WINDOW_CYC (WINDOW_CYC)
  ) u_window_timer (
    .CLK    (CLK),
    .RSTn   (RSTn),
    .clear  (timer_clear_s),
    .enable (timer_en_s),
    .expire (timer_expire_s)
  );

  // Sequence FSM, click counter and registered event/busy outputs
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state_r    <= ST_IDLE;
      count_r    <= {CNT_W{1'b0}};
      Single_Sig <= 1'b0;
      Double_Sig <= 1'b0;
      Multi_Sig  <= 1'b0;
      Busy       <= 1'b0;
`ifdef CLICK_CNT_OUT_EN
      Click_Cnt  <= {CNT_W{1'b0}};
`endif
    end else begin
      Single_Sig <= 1'b0;
      Double_Sig <= 1'b0;
      Multi_Sig  <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (Press_Pulse) begin
            count_r <= CNT_W'(1);
            state_r <= ST_WAIT;
            Busy    <= 1'b1;
          end else begin
            state_r <= ST_IDLE;
            Busy    <= 1'b0;
          end
        end
        ST_WAIT: begin
          // A press on the expiry cycle wins and reopens the window
          if (Press_Pulse) begin
            count_r <= count_inc_s;
            state_r <= ST_WAIT;
            Busy    <= 1'b1;
          end else if (timer_expire_s) begin
            state_r <= ST_EMIT;
            Busy    <= 1'b0;
            if (count_r == CNT_W'(1)) begin
              Single_Sig <= 1'b1;
            end else if (count_r == CNT_W'(2)) begin
              Double_Sig <= 1'b1;
            end else begin
              Multi_Sig <= 1'b1;
            end
`ifdef CLICK_CNT_OUT_EN
            Click_Cnt <= count_r;
`endif
          end else begin
            state_r <= ST_WAIT;
            Busy    <= 1'b1;
          end
        end
        ST_EMIT: begin
          if (Press_Pulse) begin
            count_r <= CNT_W'(1);
            state_r <= ST_WAIT;
            Busy    <= 1'b1;
          end else begin
            state_r <= ST_IDLE;
            Busy    <= 1'b0;
          end
        end
        default: begin
          state_r <= ST_IDLE;
          count_r <= {CNT_W{1'b0}};
          Busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_key_click_classifier.sv
// Scoreboard bench for key_click_classifier (WINDOW_CYC=8, MAX_CLICKS=3).
// Expected events are queued from the press schedule and matched by a monitor.
module tb_key_click_classifier;

  localparam int WIN   = 8;
  localparam int MAXC  = 3;
  localparam int CNT_W = $clog2(MAXC + 1);

  localparam logic [2:0] EV_SINGLE = 3'b001;
  localparam logic [2:0] EV_DOUBLE = 3'b010;
  localparam logic [2:0] EV_MULTI  = 3'b100;

  typedef struct {
    int cyc;
    int kind;
    int cnt;
  } exp_t;

  logic CLK = 1'b0;
  logic RSTn = 1'b0;
  logic Press_Pulse = 1'b0;
  logic Single_Sig, Double_Sig, Multi_Sig, Busy;
  logic [CNT_W-1:0] Click_Cnt;

  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   base = 0;
  int   press_set[$];
  exp_t exp_q[$];

  key_click_classifier #(
    .WINDOW_CYC (WIN),
    .MAX_CLICKS (MAXC)
  ) dut (
    .CLK         (CLK),
    .RSTn        (RSTn),
    .Press_Pulse (Press_Pulse),
    .Single_Sig  (Single_Sig),
    .Double_Sig  (Double_Sig),
    .Multi_Sig   (Multi_Sig),
    .Busy        (Busy)
`ifdef CLICK_CNT_OUT_EN
    ,
    .Click_Cnt   (Click_Cnt)
`endif
  );

`ifndef CLICK_CNT_OUT_EN
  assign Click_Cnt = '0;
`endif

  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0d expected %0d", tag, cyc, got, exp);
    end
  endtask

  task automatic push_exp(input int rel_cyc, input logic [2:0] kind, input int cnt);
    exp_t e;
    e.cyc  = base + rel_cyc;
    e.kind = int'(kind);
    e.cnt  = cnt;
    exp_q.push_back(e);
  endtask

  // Monitor: every event pulse must match the head of the scoreboard
  always @(negedge CLK) begin
    logic [2:0] ev;
    exp_t e;
    ev = {Multi_Sig, Double_Sig, Single_Sig};
    if (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
      check_eq("evt_missed", cyc, exp_q[0].cyc);
      void'(exp_q.pop_front());
    end
    if (ev != 3'b000) begin
      if (exp_q.size() == 0) begin
        check_eq("evt_unexpected", int'(ev), 0);
      end else begin
        e = exp_q.pop_front();
        check_eq("evt_cycle", cyc, e.cyc);
        check_eq("evt_kind", int'(ev), e.kind);
`ifdef CLICK_CNT_OUT_EN
        check_eq("click_cnt", int'(Click_Cnt), e.cnt);
`endif
      end
    end
  end

  // Drive press_set (cycles relative to base) for len cycles, with optional
  // Busy checks and an optional reset pulse starting at relative cycle rst_at
  task automatic run_scn(input int len, input bit chk_busy, input int rst_at);
    int rel;
    bit press;
    base = cyc;
    for (int n = 0; n < len; n++) begin
      @(negedge CLK);
      rel = cyc - base;
      if (chk_busy) begin
        if (rel >= 11 && rel <= 17) check_eq("busy_open", int'(Busy), 1);
        if (rel == 9 || rel == 18)  check_eq("busy_closed", int'(Busy), 0);
      end
      if (rst_at >= 0 && rel == rst_at - 1) RSTn = 1'b0;
      if (rst_at >= 0 && rel == rst_at + 1) begin
        check_eq("rst_busy", int'(Busy), 0);
        check_eq("rst_events", int'({Multi_Sig, Double_Sig, Single_Sig}), 0);
        RSTn = 1'b1;
      end
      press = 1'b0;
      foreach (press_set[i]) if (base + press_set[i] == cyc + 1) press = 1'b1;
      Press_Pulse = press;
    end
    Press_Pulse = 1'b0;
    check_eq("queue_drained", exp_q.size(), 0);
  endtask

  initial begin
    RSTn = 1'b0;
    repeat (3) @(negedge CLK);
    check_eq("reset_busy", int'(Busy), 0);
    check_eq("reset_events", int'({Multi_Sig, Double_Sig, Single_Sig}), 0);
`ifdef CLICK_CNT_OUT_EN
    check_eq("reset_cnt", int'(Click_Cnt), 0);
`endif
    RSTn = 1'b1;
    repeat (2) @(negedge CLK);

    // Single click
    press_set = '{10};
    base = cyc;
    push_exp(18, EV_SINGLE, 1);
    run_scn(30, 1'b1, -1);

    // Double click
    press_set = '{10, 14};
    base = cyc;
    push_exp(22, EV_DOUBLE, 2);
    run_scn(35, 1'b0, -1);

    // Five clicks saturate to Multi
    press_set = '{10, 14, 18, 22, 26};
    base = cyc;
    push_exp(34, EV_MULTI, 3);
    run_scn(45, 1'b0, -1);

    // Press coincides with window expiry: window restarts, no event at 18
    press_set = '{10, 18};
    base = cyc;
    push_exp(26, EV_DOUBLE, 2);
    run_scn(40, 1'b0, -1);

    // Press sampled while the first event is showing starts a new sequence
    press_set = '{10, 19};
    base = cyc;
    push_exp(18, EV_SINGLE, 1);
    push_exp(27, EV_SINGLE, 1);
    run_scn(40, 1'b0, -1);

    // Reset mid-sequence discards it; later press classifies normally
    press_set = '{10, 30};
    base = cyc;
    push_exp(38, EV_SINGLE, 1);
    run_scn(50, 1'b0, 14);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
